// File: rtl/status_ctrl.sv
// status_ctrl: per-channel start/done handshake between a PS control word and PL.
// Define STATUS_TIMEOUT_EN to add a per-channel watchdog and the ERR state.
module status_ctrl #(
    parameter int NCH            = 4,
    parameter int STATUS_ADDR    = 0,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [63:0]    dout,
    output logic [31:0]    din,
    output logic [1:0]     addr,
    output logic           wen,
    output logic [NCH-1:0] in_data_valid,
    input  logic [NCH-1:0] out_data_valid
);

`ifdef STATUS_TIMEOUT_EN
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_ERR} state_t;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
`else
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    localparam int unused_tmo = TIMEOUT_CYCLES;
`endif

    logic [NCH-1:0] start, ack, start_rise;
    logic           clr_rise;
    logic [NCH-1:0] prev_start_q;
    logic           prev_clr_q;
    state_t         state_q [NCH];
    state_t         state_d [NCH];
    logic [NCH-1:0] ovr_q, ovr_d, ovr_set;
    logic [NCH-1:0] idv_q, idv_d;
    logic [31:0]    din_q, din_d;
    logic           unused_dout;
`ifdef STATUS_TIMEOUT_EN
    logic [CW-1:0]  cnt_q [NCH];
    logic [CW-1:0]  cnt_d [NCH];
`endif

    assign start       = dout[32 +: NCH];
    assign ack         = dout[40 +: NCH];
    assign start_rise  = start & ~prev_start_q;
    assign clr_rise    = dout[48] & ~prev_clr_q;
    assign unused_dout = ^dout;

    assign din           = din_q;
    assign addr          = 2'(STATUS_ADDR);
    assign wen           = 1'b1;
    assign in_data_valid = idv_q;

    always_comb begin
        state_d = state_q;
        idv_d   = '0;
        ovr_set = '0;
`ifdef STATUS_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        for (int i = 0; i < NCH; i++) begin
            unique case (state_q[i])
                S_IDLE: begin
                    if (start_rise[i]) begin
                        state_d[i] = S_BUSY;
                        idv_d[i]   = 1'b1;
`ifdef STATUS_TIMEOUT_EN
                        cnt_d[i]   = '0;
`endif
                    end
                end
                S_BUSY: begin
                    // A start while busy is dropped and flagged as overrun
                    if (start_rise[i]) ovr_set[i] = 1'b1;
                    if (out_data_valid[i]) state_d[i] = S_DONE;
`ifdef STATUS_TIMEOUT_EN
                    else if (cnt_q[i] == CW'(TIMEOUT_CYCLES - 1))
                        state_d[i] = S_ERR;
                    else
                        cnt_d[i] = cnt_q[i] + 1'b1;
`endif
                end
                S_DONE: begin
                    if (start_rise[i]) begin
                        state_d[i] = S_BUSY;
                        idv_d[i]   = 1'b1;
`ifdef STATUS_TIMEOUT_EN
                        cnt_d[i]   = '0;
`endif
                    end else if (ack[i]) begin
                        state_d[i] = S_IDLE;
                    end
                end
`ifdef STATUS_TIMEOUT_EN
                S_ERR: begin
                    if (start_rise[i]) ovr_set[i] = 1'b1;
                    if (ack[i]) state_d[i] = S_IDLE;
                end
`endif
                default: state_d[i] = S_IDLE;
            endcase
        end
    end

    // A new overrun in the clearing cycle survives the clear
    assign ovr_d = (clr_rise ? '0 : ovr_q) | ovr_set;

    always_comb begin
        din_d = '0;
        for (int i = 0; i < NCH; i++) begin
            din_d[i]      = (state_q[i] == S_DONE);
            din_d[8 + i]  = (state_q[i] == S_BUSY);
            din_d[16 + i] = ovr_q[i];
`ifdef STATUS_TIMEOUT_EN
            din_d[24 + i] = (state_q[i] == S_ERR);
`endif
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev_start_q <= '1;
            prev_clr_q   <= 1'b1;
            ovr_q        <= '0;
            idv_q        <= '0;
            din_q        <= '0;
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= S_IDLE;
`ifdef STATUS_TIMEOUT_EN
                cnt_q[i]   <= '0;
`endif
            end
        end else begin
            prev_start_q <= start;
            prev_clr_q   <= dout[48];
            ovr_q        <= ovr_d;
            idv_q        <= idv_d;
            din_q        <= din_d;
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
`ifdef STATUS_TIMEOUT_EN
                cnt_q[i]   <= cnt_d[i];
`endif
            end
        end
    end

endmodule

// File: tb/tb_status_ctrl.sv
// tb_status_ctrl: directed and random checks of status_ctrl against a flag-level model.
// Timeout scenarios are exercised when STATUS_TIMEOUT_EN is defined.
module tb_status_ctrl;

    localparam int NCH = 4;
    localparam int TMO = 16;

    logic           clk = 1'b0;
    logic           rstn = 1'b1;
    logic [63:0]    dout = '0;
    logic [31:0]    din;
    logic [1:0]     addr;
    logic           wen;
    logic [NCH-1:0] in_data_valid;
    logic [NCH-1:0] out_data_valid = '0;

    status_ctrl #(
        .NCH            (NCH),
        .STATUS_ADDR    (0),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .dout           (dout),
        .din            (din),
        .addr           (addr),
        .wen            (wen),
        .in_data_valid  (in_data_valid),
        .out_data_valid (out_data_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [NCH-1:0] start_v = '0;
    logic [NCH-1:0] ack_v   = '0;
    logic [NCH-1:0] odv_v   = '0;
    logic           clr_v   = 1'b0;

    bit [NCH-1:0]   m_busy, m_done, m_err, m_ovr, m_prev_start;
    bit             m_prev_clr;
    int             m_age [NCH];
    logic [31:0]    exp_din = '0;
    logic [NCH-1:0] exp_idv = '0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] status_word();
        logic [31:0] w = '0;
        for (int i = 0; i < NCH; i++) begin
            w[i]      = m_done[i];
            w[8 + i]  = m_busy[i];
            w[16 + i] = m_ovr[i];
            w[24 + i] = m_err[i];
        end
        return w;
    endfunction

    task automatic model_reset();
        m_busy = '0; m_done = '0; m_err = '0; m_ovr = '0;
        m_prev_start = '1;
        m_prev_clr   = 1'b1;
        for (int i = 0; i < NCH; i++) m_age[i] = 0;
        exp_din = '0;
        exp_idv = '0;
    endtask

    task automatic tick();
        logic [NCH-1:0] rise;
        bit clr_r;
        dout = {$urandom, $urandom};
        dout[32 +: NCH] = start_v;
        dout[40 +: NCH] = ack_v;
        dout[48]        = clr_v;
        out_data_valid  = odv_v;
        exp_din = status_word();
        exp_idv = '0;
        rise  = start_v & ~m_prev_start;
        clr_r = clr_v & ~m_prev_clr;
        if (clr_r) m_ovr = '0;
        for (int i = 0; i < NCH; i++) begin
            if (m_busy[i]) begin
                if (rise[i]) m_ovr[i] = 1'b1;
                if (odv_v[i]) begin
                    m_busy[i] = 1'b0;
                    m_done[i] = 1'b1;
                end
`ifdef STATUS_TIMEOUT_EN
                else begin
                    m_age[i]++;
                    if (m_age[i] == TMO) begin
                        m_busy[i] = 1'b0;
                        m_err[i]  = 1'b1;
                    end
                end
`endif
            end else if (m_done[i]) begin
                if (rise[i]) begin
                    m_done[i] = 1'b0;
                    m_busy[i] = 1'b1;
                    m_age[i]  = 0;
                    exp_idv[i] = 1'b1;
                end else if (ack_v[i]) begin
                    m_done[i] = 1'b0;
                end
            end else if (m_err[i]) begin
                if (rise[i]) m_ovr[i] = 1'b1;
                if (ack_v[i]) m_err[i] = 1'b0;
            end else if (rise[i]) begin
                m_busy[i]  = 1'b1;
                m_age[i]   = 0;
                exp_idv[i] = 1'b1;
            end
        end
        m_prev_start = start_v;
        m_prev_clr   = clr_v;
        @(posedge clk);
        #1;
        chk("din", din, exp_din);
        chk("idv", 32'(in_data_valid), 32'(exp_idv));
    endtask

    task automatic reset_dut();
        rstn = 1'b0;
        #2;
        model_reset();
        chk("rst_din", din, 32'h0);
        chk("rst_idv", 32'(in_data_valid), 32'h0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        #1;
        start_v = 4'b0001;
        dout = 64'h0000_0001_0000_0000;
        reset_dut();
        chk("addr", 32'(addr), 32'h0);
        chk("wen", 32'(wen), 32'h1);

        repeat (3) tick();
        chk("held_start_din", din, 32'h0);
        chk("held_start_idv", 32'(in_data_valid), 32'h0);

        start_v[0] = 1'b0; tick();
        start_v[0] = 1'b1; tick();
        chk("start_pulse", 32'(in_data_valid), 32'h1);
        tick();
        chk("busy0", din, 32'h0000_0100);
        chk("pulse_width", 32'(in_data_valid), 32'h0);

        odv_v[0] = 1'b1; tick();
        odv_v = '0; tick();
        chk("done0", din, 32'h0000_0001);
        ack_v[0] = 1'b1; tick(); tick();
        chk("ack0", din, 32'h0);
        ack_v = '0;

        start_v[1] = 1'b1; tick();
        chk("start1_pulse", 32'(in_data_valid), 32'h2);
        start_v[1] = 1'b0; tick();
        start_v[1] = 1'b1; tick();
        chk("ovr_no_pulse", 32'(in_data_valid), 32'h0);
        tick();
        chk("ovr1", din, 32'h0002_0200);
        clr_v = 1'b1; tick(); tick();
        chk("clr_ovr", din, 32'h0000_0200);
        clr_v = 1'b0;
        odv_v[1] = 1'b1; tick();
        odv_v = '0; ack_v[1] = 1'b1; tick(); tick();
        ack_v = '0; tick();
        chk("ch1_idle", din, 32'h0);

        start_v = '0; tick();
        start_v = 4'b1001; tick();
        chk("dual_pulse", 32'(in_data_valid), 32'h9);
        tick();
        odv_v[3] = 1'b1; tick();
        odv_v = '0; tick();
        chk("ch3_done", din, 32'h0000_0108);

        reset_dut();
        odv_v[0] = 1'b1; tick();
        odv_v = '0; tick();
        chk("late_odv", din, 32'h0);

`ifdef STATUS_TIMEOUT_EN
        start_v = '0; ack_v = '0; tick();
        start_v[2] = 1'b1; tick();
        repeat (TMO + 2) tick();
        chk("tmo_err", din, 32'h0400_0000);
        ack_v[2] = 1'b1; tick();
        ack_v = '0; tick();
        chk("tmo_ack", din, 32'h0);
        start_v[2] = 1'b0; tick();
        start_v[2] = 1'b1; tick();
        repeat (TMO - 1) tick();
        odv_v[2] = 1'b1; tick();
        odv_v = '0; tick();
        chk("tmo_race", din, 32'h0000_0004);
        ack_v[2] = 1'b1; tick();
        ack_v = '0; tick();
`endif

        for (int n = 0; n < 600; n++) begin
            if (n == 300) reset_dut();
            start_v = start_v ^ NCH'($urandom & $urandom);
            ack_v   = NCH'($urandom & $urandom);
            odv_v   = NCH'($urandom & $urandom & $urandom);
            clr_v   = ($urandom_range(0, 15) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
